elevator_call_panel: RTL and testbench

ELEVATOR_CALL_PANEL -- requirements
Module: elevator_call_panel

---
 rtl/elevator_pkg.sv | 11 +
 rtl/call_debounce.sv | 59 +++++
 rtl/elevator_call_panel.sv | 96 +++++++++
 tb/tb_elevator_call_panel.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/elevator_pkg.sv
// Shared elevator constants: default car geometry and travel-direction encoding,
// used by both the call panel and the motion controller.
package elevator_pkg;

    localparam int N_FLOORS_DEFAULT   = 4;
    localparam int FLOOR_BITS_DEFAULT = 2;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

endpackage

// File: rtl/call_debounce.sv
// One button: 2-flop synchronizer, then a stable-count debounce when
// CALL_PANEL_DEBOUNCE_EN is defined; otherwise the level is the synchronizer output.
module call_debounce #(
    parameter int DEBOUNCE_CYCLES = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_i,
    output logic level_o
);

    logic [1:0] sync_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[0], btn_i};
        end
    end

`ifdef CALL_PANEL_DEBOUNCE_EN
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          level_q, level_d;

    // The counter only runs while the synchronized input disagrees with the
    // accepted level, so any bounce back to the old level restarts it.
    always_comb begin
        cnt_d   = '0;
        level_d = level_q;
        if (sync_q[1] != level_q) begin
            if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
                level_d = sync_q[1];
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= '0;
            level_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            level_q <= level_d;
        end
    end

    assign level_o = level_q;
`else
    logic unused_debounce_cycles;
    assign unused_debounce_cycles = |DEBOUNCE_CYCLES;
    assign level_o = sync_q[1];
`endif

endmodule

// File: rtl/elevator_call_panel.sv
// Call panel: conditions car/hall buttons, emits one-cycle request pulses and holds
// lamps until serviced. Debounce stage enabled by macro CALL_PANEL_DEBOUNCE_EN.
module elevator_call_panel
    import elevator_pkg::*;
#(
    parameter int N_FLOORS        = N_FLOORS_DEFAULT,
    parameter int FLOOR_BITS      = FLOOR_BITS_DEFAULT,
    parameter int DEBOUNCE_CYCLES = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_FLOORS-1:0]   inside_btn,
    input  logic [N_FLOORS-1:0]   up_btn,
    input  logic [N_FLOORS-1:0]   down_btn,
    input  logic [FLOOR_BITS-1:0] current_floor,
    input  logic                  door_open,
    input  logic                  direction,
    output logic [N_FLOORS-1:0]   inside_req,
    output logic [N_FLOORS-1:0]   up_call,
    output logic [N_FLOORS-1:0]   down_call,
    output logic [N_FLOORS-1:0]   inside_lamp,
    output logic [N_FLOORS-1:0]   up_lamp,
    output logic [N_FLOORS-1:0]   down_lamp,
    output logic                  any_pending
);

    localparam int NB = 3 * N_FLOORS;

    // Flattened bit order: [N-1:0] car, [2N-1:N] hall-up, [3N-1:2N] hall-down.
    logic [NB-1:0] raw_btn;
    logic [NB-1:0] level;
    logic [NB-1:0] prev_q, rise_q;
    logic [NB-1:0] pulse_q, pulse_d;
    logic [NB-1:0] lamp_q, lamp_d;
    logic [NB-1:0] clr;
    logic          pend_q;

    assign raw_btn = {down_btn, up_btn, inside_btn};

    for (genvar g = 0; g < NB; g++) begin : g_btn
        call_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_deb (
            .clk     (clk),
            .rst     (rst),
            .btn_i   (raw_btn[g]),
            .level_o (level[g])
        );
    end

    always_comb begin
        clr = '0;
        for (int i = 0; i < N_FLOORS; i++) begin
            if (door_open && (32'(current_floor) == 32'(i))) begin
                clr[i]              = 1'b1;
                clr[N_FLOORS + i]   = (direction == DIR_UP) || (i == 0);
                clr[2*N_FLOORS + i] = (direction == DIR_DOWN) || (i == N_FLOORS - 1);
            end
        end

        // An edge landing on a bit that is being serviced this cycle is absorbed.
        pulse_d = rise_q & ~lamp_q & ~clr;
        lamp_d  = (lamp_q | pulse_d) & ~clr;

        // Top-floor up and ground-floor down calls do not exist.
        pulse_d[2*N_FLOORS - 1] = 1'b0;
        pulse_d[2*N_FLOORS]     = 1'b0;
        lamp_d[2*N_FLOORS - 1]  = 1'b0;
        lamp_d[2*N_FLOORS]      = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_q  <= '0;
            rise_q  <= '0;
            pulse_q <= '0;
            lamp_q  <= '0;
            pend_q  <= 1'b0;
        end else begin
            prev_q  <= level;
            rise_q  <= level & ~prev_q;
            pulse_q <= pulse_d;
            lamp_q  <= lamp_d;
            pend_q  <= |lamp_q;
        end
    end

    assign inside_req  = pulse_q[N_FLOORS-1:0];
    assign up_call     = pulse_q[2*N_FLOORS-1:N_FLOORS];
    assign down_call   = pulse_q[NB-1:2*N_FLOORS];
    assign inside_lamp = lamp_q[N_FLOORS-1:0];
    assign up_lamp     = lamp_q[2*N_FLOORS-1:N_FLOORS];
    assign down_lamp   = lamp_q[NB-1:2*N_FLOORS];
    assign any_pending = pend_q;

endmodule

// File: tb/tb_elevator_call_panel.sv
// Directed bench for elevator_call_panel; expected latencies follow whether
// CALL_PANEL_DEBOUNCE_EN is defined for the build.
module tb_elevator_call_panel;

    localparam int DEB_CYC = 8;
`ifdef CALL_PANEL_DEBOUNCE_EN
    localparam int LAT       = 3 + DEB_CYC;
    localparam int GLITCH_OK = 0;
`else
    localparam int LAT       = 3;
    localparam int GLITCH_OK = 1;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] inside_btn, up_btn, down_btn;
    logic [1:0] current_floor;
    logic       door_open, direction;
    logic [3:0] inside_req, up_call, down_call;
    logic [3:0] inside_lamp, up_lamp, down_lamp;
    logic       any_pending;

    logic [11:0] all_req, all_lamp;
    assign all_req  = {down_call, up_call, inside_req};
    assign all_lamp = {down_lamp, up_lamp, inside_lamp};

    int n_checks = 0;
    int n_fail   = 0;
    int pcnt;

    elevator_call_panel #(
        .N_FLOORS        (4),
        .FLOOR_BITS      (2),
        .DEBOUNCE_CYCLES (DEB_CYC)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .inside_btn    (inside_btn),
        .up_btn        (up_btn),
        .down_btn      (down_btn),
        .current_floor (current_floor),
        .door_open     (door_open),
        .direction     (direction),
        .inside_req    (inside_req),
        .up_call       (up_call),
        .down_call     (down_call),
        .inside_lamp   (inside_lamp),
        .up_lamp       (up_lamp),
        .down_lamp     (down_lamp),
        .any_pending   (any_pending)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Steps n cycles and totals every request pulse bit seen.
    task automatic count_pulses(input int n, output int cnt);
        cnt = 0;
        for (int k = 0; k < n; k++) begin
            step(1);
            cnt += $countones(all_req);
        end
    endtask

    initial begin
        rst = 1'b1;
        inside_btn = '0; up_btn = '0; down_btn = '0;
        current_floor = '0; door_open = 1'b0; direction = 1'b0;
        step(3);
        check("reset_outputs", {19'd0, all_req, any_pending}, 32'd0);
        check("reset_lamps", {20'd0, all_lamp}, 32'd0);
        rst = 1'b0;
        step(2);

        // Car button 2: exact latency, single pulse, lamp and any_pending timing.
        inside_btn[2] = 1'b1;
        step(LAT);
        check("car2_pre_pulse", {28'd0, inside_req}, 32'd0);
        step(1);
        check("car2_pulse", {28'd0, inside_req}, 32'h4);
        check("car2_lamp_same_cycle", {28'd0, inside_lamp}, 32'h4);
        check("pending_lag", {31'd0, any_pending}, 32'd0);
        step(1);
        check("car2_pulse_end", {28'd0, inside_req}, 32'd0);
        check("pending_set", {31'd0, any_pending}, 32'd1);
        count_pulses(20, pcnt);
        check("car2_held_no_repulse", pcnt, 0);
        inside_btn[2] = 1'b0;
        step(LAT + 2);
        inside_btn[2] = 1'b1;
        count_pulses(LAT + 4, pcnt);
        check("car2_repress_no_pulse", pcnt, 0);

        // Service floor 2 while the button is still held: lamp clears, no re-register.
        current_floor = 2'd2; door_open = 1'b1;
        step(1);
        check("car2_cleared", {28'd0, inside_lamp}, 32'd0);
        door_open = 1'b0; inside_btn[2] = 1'b0;
        step(1);
        check("pending_clear", {31'd0, any_pending}, 32'd0);

        // Three-cycle glitch on car button 1.
        inside_btn[1] = 1'b1;
        step(3);
        inside_btn[1] = 1'b0;
        count_pulses(LAT + 3, pcnt);
        check("glitch_pulses", pcnt, GLITCH_OK);
        check("glitch_lamp", {28'd0, inside_lamp}, GLITCH_OK * 2);
        current_floor = 2'd1; door_open = 1'b1;
        step(1);
        door_open = 1'b0;
        check("glitch_lamp_cleared", {28'd0, inside_lamp}, 32'd0);

        // Hall calls: up 0, up 1, down 1 pressed together.
        up_btn[0] = 1'b1; up_btn[1] = 1'b1; down_btn[1] = 1'b1;
        step(LAT);
        check("hall_pre_pulse", {20'd0, all_req}, 32'd0);
        step(1);
        check("up_call_pulse", {28'd0, up_call}, 32'h3);
        check("down_call_pulse", {28'd0, down_call}, 32'h2);
        step(1);
        check("hall_lamps", {20'd0, all_lamp}, 32'h230);
        up_btn = '0; down_btn = '0;

        // Directional service at floor 1, then floor 0 clears up regardless of direction.
        current_floor = 2'd1; door_open = 1'b1; direction = 1'b1;
        step(1);
        check("f1_up_clear_up", {28'd0, up_lamp}, 32'h1);
        check("f1_up_keep_down", {28'd0, down_lamp}, 32'h2);
        direction = 1'b0;
        step(1);
        check("f1_down_clear_down", {28'd0, down_lamp}, 32'h0);
        check("f1_down_keep_up", {28'd0, up_lamp}, 32'h1);
        current_floor = 2'd0;
        step(1);
        check("f0_up_clear_dir_down", {28'd0, up_lamp}, 32'h0);
        door_open = 1'b0;

        // Top floor, door open, going up: down_btn[3] absorbed, car 0 independent.
        current_floor = 2'd3; door_open = 1'b1; direction = 1'b1;
        down_btn[3] = 1'b1; inside_btn[0] = 1'b1;
        count_pulses(LAT + 3, pcnt);
        check("top_absorb_pulses", pcnt, 1);
        check("top_absorb_down_lamp", {28'd0, down_lamp}, 32'h0);
        check("independent_car0_lamp", {28'd0, inside_lamp}, 32'h1);
        down_btn = '0; inside_btn = '0; door_open = 1'b0;

        // Nonexistent hall calls never register.
        up_btn[3] = 1'b1; down_btn[0] = 1'b1;
        count_pulses(LAT + 5, pcnt);
        check("masked_pulses", pcnt, 0);
        check("masked_lamps", {24'd0, up_lamp, down_lamp}, 32'h0);
        check("pending_before_rst", {31'd0, any_pending}, 32'd1);

        // Reset with a lamp lit and a car button held through release.
        inside_btn[3] = 1'b1;
        rst = 1'b1;
        step(1);
        check("rst_clears_all", {7'd0, all_req, all_lamp, any_pending}, 32'd0);
        step(1);
        rst = 1'b0;
        step(LAT);
        check("held_rst_pre_pulse", {28'd0, inside_req}, 32'd0);
        step(1);
        check("held_rst_pulse", {28'd0, inside_req}, 32'h8);
        count_pulses(10, pcnt);
        check("held_rst_single", pcnt, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
